// File: rtl/nv_nvdla_cdma_wt_dma_req_pipe.sv
// rtl/nv_nvdla_cdma_wt_dma_req_pipe.sv - CDMA weight DMA request pipe with credit and tag tracking
// Optional perf counters are enabled by defining NVDLA_CDMA_WT_REQ_PERF_EN.
module nv_nvdla_cdma_wt_dma_req_pipe #(
  parameter int AW            = 64,
  parameter int SW            = 15,
  parameter int MAX_REQ_ATOMS = 32,
  parameter int CREDIT        = 256,
  parameter int TAG_DEPTH     = 8
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          req0_vld,
  input  logic [AW-1:0] req0_addr,
  input  logic [SW-1:0] req0_size,
  input  logic          req1_vld,
  input  logic [AW-1:0] req1_addr,
  input  logic [SW-1:0] req1_size,
  input  logic          gnt0,
  input  logic          gnt1,
  output logic          gnt_busy,
  output logic          req0_rdy,
  output logic          req1_rdy,
  output logic          dma_rd_req_vld,
  output logic [AW-1:0] dma_rd_req_addr,
  output logic [SW-1:0] dma_rd_req_size,
  input  logic          dma_rd_req_rdy,
  input  logic          credit_ret,
  input  logic          rsp_done,
  output logic          rsp_src,
  output logic          rsp_src_vld,
  output logic          err
`ifdef NVDLA_CDMA_WT_REQ_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_req0_cnt,
  output logic [31:0]   perf_req1_cnt
`endif
);

  localparam int CW = $clog2(CREDIT + 1);
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int XW = ((SW > CW) ? SW : CW) + 2;

  logic [CW-1:0]        credit_avail;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW:0]          tag_cnt;
  logic [TAG_DEPTH-1:0] tag_mem;

  logic          acc0, acc1, accept;
  logic [AW-1:0] acc_addr;
  logic [SW-1:0] acc_size;
  logic          pop, pop_err;
  logic [XW-1:0] credit_pos, credit_neg, credit_diff;
  logic          credit_under, credit_over;
  logic          err_set;

  // Busy depends only on state and dma_rd_req_rdy, never on the grants.
  assign gnt_busy = (dma_rd_req_vld && !dma_rd_req_rdy)
                 || (credit_avail < CW'(MAX_REQ_ATOMS))
                 || (tag_cnt == (PW+1)'(TAG_DEPTH));

  assign acc0     = gnt0 && !gnt_busy;
  assign acc1     = gnt1 && !gnt0 && !gnt_busy;
  assign accept   = acc0 || acc1;
  assign req0_rdy = acc0;
  assign req1_rdy = acc1;
  assign acc_addr = acc0 ? req0_addr : req1_addr;
  assign acc_size = acc0 ? req0_size : req1_size;

  assign pop     = rsp_done && (tag_cnt != '0);
  assign pop_err = rsp_done && (tag_cnt == '0);

  // Credit math is done wide so a huge illegal size cannot wrap the counter.
  assign credit_pos   = XW'(credit_avail) + XW'(credit_ret);
  assign credit_neg   = accept ? (XW'(acc_size) + XW'(1)) : '0;
  assign credit_under = credit_neg > credit_pos;
  assign credit_diff  = credit_pos - credit_neg;
  assign credit_over  = !credit_under && (credit_diff > XW'(CREDIT));

  assign err_set = (gnt0 && gnt1)
                || ((gnt0 || gnt1) && gnt_busy)
                || (accept && (acc_size >= SW'(MAX_REQ_ATOMS)))
                || pop_err
                || credit_over;

  assign rsp_src     = tag_mem[rd_ptr];
  assign rsp_src_vld = (tag_cnt != '0);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      dma_rd_req_vld  <= 1'b0;
      dma_rd_req_addr <= '0;
      dma_rd_req_size <= '0;
      credit_avail    <= CW'(CREDIT);
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      tag_cnt         <= '0;
      tag_mem         <= '0;
      err             <= 1'b0;
    end else begin
      if (accept) begin
        dma_rd_req_vld  <= 1'b1;
        dma_rd_req_addr <= acc_addr;
        dma_rd_req_size <= acc_size;
      end else if (dma_rd_req_rdy) begin
        dma_rd_req_vld  <= 1'b0;
      end

      if (credit_under)
        credit_avail <= '0;
      else if (credit_over)
        credit_avail <= CW'(CREDIT);
      else
        credit_avail <= credit_diff[CW-1:0];

      if (accept) begin
        tag_mem[wr_ptr] <= acc1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      tag_cnt <= tag_cnt + (PW+1)'(accept) - (PW+1)'(pop);

      if (err_set)
        err <= 1'b1;
    end
  end

`ifdef NVDLA_CDMA_WT_REQ_PERF_EN
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      perf_stall_cnt <= '0;
      perf_req0_cnt  <= '0;
      perf_req1_cnt  <= '0;
    end else begin
      if ((req0_vld || req1_vld) && gnt_busy && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (acc0)
        perf_req0_cnt <= perf_req0_cnt + 32'd1;
      if (acc1)
        perf_req1_cnt <= perf_req1_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nv_nvdla_cdma_wt_dma_req_pipe.sv
// tb/tb_nv_nvdla_cdma_wt_dma_req_pipe.sv - directed self-checking bench for the weight DMA request pipe
module tb_nv_nvdla_cdma_wt_dma_req_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_vld, req1_vld;
  logic [63:0] req0_addr, req1_addr;
  logic [14:0] req0_size, req1_size;
  logic        gnt0, gnt1;
  logic        gnt_busy, req0_rdy, req1_rdy;
  logic        dma_rd_req_vld;
  logic [63:0] dma_rd_req_addr;
  logic [14:0] dma_rd_req_size;
  logic        dma_rd_req_rdy;
  logic        credit_ret, rsp_done;
  logic        rsp_src, rsp_src_vld, err;
`ifdef NVDLA_CDMA_WT_REQ_PERF_EN
  logic [31:0] perf_stall_cnt, perf_req0_cnt, perf_req1_cnt;
`endif

  integer errors = 0;
  integer checks = 0;

  always #5 clk = ~clk;

  nv_nvdla_cdma_wt_dma_req_pipe dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rst  (rst),
    .req0_vld        (req0_vld),
    .req0_addr       (req0_addr),
    .req0_size       (req0_size),
    .req1_vld        (req1_vld),
    .req1_addr       (req1_addr),
    .req1_size       (req1_size),
    .gnt0            (gnt0),
    .gnt1            (gnt1),
    .gnt_busy        (gnt_busy),
    .req0_rdy        (req0_rdy),
    .req1_rdy        (req1_rdy),
    .dma_rd_req_vld  (dma_rd_req_vld),
    .dma_rd_req_addr (dma_rd_req_addr),
    .dma_rd_req_size (dma_rd_req_size),
    .dma_rd_req_rdy  (dma_rd_req_rdy),
    .credit_ret      (credit_ret),
    .rsp_done        (rsp_done),
    .rsp_src         (rsp_src),
    .rsp_src_vld     (rsp_src_vld),
    .err             (err)
`ifdef NVDLA_CDMA_WT_REQ_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_req0_cnt   (perf_req0_cnt),
    .perf_req1_cnt   (perf_req1_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_vld = 0; req1_vld = 0; req0_addr = '0; req1_addr = '0;
    req0_size = '0; req1_size = '0; gnt0 = 0; gnt1 = 0;
    dma_rd_req_rdy = 1'b1; credit_ret = 0; rsp_done = 0;
    tick(); tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dma_rd_req_vld !== 1'b0 || dma_rd_req_addr !== 64'd0 || dma_rd_req_size !== 15'd0) begin
      errors++;
      $display("FAIL reset_pipe: vld=%b addr=%h size=%0d expected 0/0/0", dma_rd_req_vld, dma_rd_req_addr, dma_rd_req_size);
    end
    checks++;
    if (rsp_src_vld !== 1'b0 || rsp_src !== 1'b0 || err !== 1'b0 || gnt_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: src_vld=%b src=%b err=%b busy=%b expected 0/0/0/0", rsp_src_vld, rsp_src, err, gnt_busy);
    end
    checks++;
    if (dut.credit_avail !== 9'd256) begin
      errors++;
      $display("FAIL reset_credit: got %0d expected 256", dut.credit_avail);
    end
  endtask

  task automatic test_single();
    do_reset();
    req0_vld = 1; req0_addr = 64'h1000; req0_size = 15'd3; gnt0 = 1;
    settle();
    checks++;
    if (req0_rdy !== 1'b1 || req1_rdy !== 1'b0) begin
      errors++;
      $display("FAIL single_rdy: rdy0=%b rdy1=%b expected 1/0", req0_rdy, req1_rdy);
    end
    tick();
    gnt0 = 0; req0_vld = 0;
    settle();
    checks++;
    if (dma_rd_req_vld !== 1'b1 || dma_rd_req_addr !== 64'h1000 || dma_rd_req_size !== 15'd3) begin
      errors++;
      $display("FAIL single_payload: vld=%b addr=%h size=%0d expected 1/1000/3", dma_rd_req_vld, dma_rd_req_addr, dma_rd_req_size);
    end
    checks++;
    if (dut.credit_avail !== 9'd252 || rsp_src_vld !== 1'b1 || rsp_src !== 1'b0) begin
      errors++;
      $display("FAIL single_state: credit=%0d src_vld=%b src=%b expected 252/1/0", dut.credit_avail, rsp_src_vld, rsp_src);
    end
    tick();
    checks++;
    if (dma_rd_req_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: vld=%b expected 0", dma_rd_req_vld);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    dma_rd_req_rdy = 0;
    req1_vld = 1; req1_addr = 64'h2222_0000; req1_size = 15'd7; gnt1 = 1;
    tick();
    gnt1 = 0; req1_vld = 0; req1_addr = 64'h0; req1_size = 15'd0;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if (gnt_busy !== 1'b1 || dma_rd_req_vld !== 1'b1 || dma_rd_req_addr !== 64'h2222_0000 || dma_rd_req_size !== 15'd7) begin
        errors++;
        $display("FAIL bp_stall[%0d]: busy=%b vld=%b addr=%h size=%0d expected 1/1/22220000/7", i, gnt_busy, dma_rd_req_vld, dma_rd_req_addr, dma_rd_req_size);
      end
      tick();
    end
    dma_rd_req_rdy = 1;
    settle();
    checks++;
    if (gnt_busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release_busy: got %b expected 0", gnt_busy);
    end
    tick();
    checks++;
    if (dma_rd_req_vld !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: vld=%b expected 0", dma_rd_req_vld);
    end
  endtask

  task automatic test_credit();
    do_reset();
    req0_size = 15'd31;
    for (int i = 0; i < 7; i++) begin
      req0_addr = 64'h4000 + 64'(i * 32);
      gnt0 = 1; rsp_done = (i > 0);
      tick();
    end
    gnt0 = 0; rsp_done = 0;
    settle();
    checks++;
    if (dut.credit_avail !== 9'd32 || gnt_busy !== 1'b0) begin
      errors++;
      $display("FAIL credit_224: credit=%0d busy=%b expected 32/0", dut.credit_avail, gnt_busy);
    end
    gnt0 = 1; rsp_done = 1;
    tick();
    gnt0 = 0; rsp_done = 0;
    settle();
    checks++;
    if (dut.credit_avail !== 9'd0 || gnt_busy !== 1'b1) begin
      errors++;
      $display("FAIL credit_empty: credit=%0d busy=%b expected 0/1", dut.credit_avail, gnt_busy);
    end
    credit_ret = 1;
    tick();
    credit_ret = 0;
    settle();
    checks++;
    if (dut.credit_avail !== 9'd1 || gnt_busy !== 1'b1) begin
      errors++;
      $display("FAIL credit_one: credit=%0d busy=%b expected 1/1", dut.credit_avail, gnt_busy);
    end
    credit_ret = 1;
    for (int i = 0; i < 31; i++) tick();
    credit_ret = 0;
    settle();
    checks++;
    if (dut.credit_avail !== 9'd32 || gnt_busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL credit_back: credit=%0d busy=%b err=%b expected 32/0/0", dut.credit_avail, gnt_busy, err);
    end
  endtask

  task automatic test_tags();
    logic [7:0] srcs;
    srcs = 8'b0100_1101;  // bit i is the source of grant i: 1,0,1,1,0,0,1,0
    do_reset();
    req0_addr = 64'hA0; req1_addr = 64'hB0;
    for (int i = 0; i < 8; i++) begin
      gnt0 = !srcs[i]; gnt1 = srcs[i];
      tick();
    end
    gnt0 = 0; gnt1 = 0;
    settle();
    checks++;
    if (gnt_busy !== 1'b1 || rsp_src_vld !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL tag_full: busy=%b src_vld=%b err=%b expected 1/1/0", gnt_busy, rsp_src_vld, err);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rsp_src !== srcs[i] || rsp_src_vld !== 1'b1) begin
        errors++;
        $display("FAIL tag_order[%0d]: src=%b vld=%b expected %b/1", i, rsp_src, rsp_src_vld, srcs[i]);
      end
      rsp_done = 1;
      tick();
      rsp_done = 0;
      settle();
    end
    checks++;
    if (rsp_src_vld !== 1'b0 || gnt_busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL tag_empty: src_vld=%b busy=%b err=%b expected 0/0/0", rsp_src_vld, gnt_busy, err);
    end
  endtask

  task automatic test_errors();
    do_reset();
    req0_addr = 64'hA; req0_size = 15'd2; req1_addr = 64'hB; req1_size = 15'd5;
    gnt0 = 1; gnt1 = 1;
    settle();
    checks++;
    if (req0_rdy !== 1'b1 || req1_rdy !== 1'b0) begin
      errors++;
      $display("FAIL dual_rdy: rdy0=%b rdy1=%b expected 1/0", req0_rdy, req1_rdy);
    end
    tick();
    gnt0 = 0; gnt1 = 0;
    settle();
    checks++;
    if (err !== 1'b1 || dma_rd_req_addr !== 64'hA || dma_rd_req_size !== 15'd2) begin
      errors++;
      $display("FAIL dual_grant: err=%b addr=%h size=%0d expected 1/a/2", err, dma_rd_req_addr, dma_rd_req_size);
    end

    do_reset();
    checks++;
    if (err !== 1'b0 || dut.credit_avail !== 9'd256) begin
      errors++;
      $display("FAIL reset_clears: err=%b credit=%0d expected 0/256", err, dut.credit_avail);
    end
    rsp_done = 1;
    tick();
    rsp_done = 0;
    req1_addr = 64'hC0; req1_size = 15'd0; gnt1 = 1;
    tick();
    gnt1 = 0;
    settle();
    checks++;
    if (err !== 1'b1 || rsp_src_vld !== 1'b1 || rsp_src !== 1'b1) begin
      errors++;
      $display("FAIL empty_pop: err=%b src_vld=%b src=%b expected 1/1/1", err, rsp_src_vld, rsp_src);
    end
    rsp_done = 1;
    tick();
    rsp_done = 0;
    settle();
    checks++;
    if (rsp_src_vld !== 1'b0) begin
      errors++;
      $display("FAIL empty_pop_count: src_vld=%b expected 0", rsp_src_vld);
    end

    do_reset();
    req0_addr = 64'h5000; req0_size = 15'd40; gnt0 = 1;
    tick();
    gnt0 = 0;
    settle();
    checks++;
    if (err !== 1'b1 || dma_rd_req_vld !== 1'b1 || dma_rd_req_size !== 15'd40 || dut.credit_avail !== 9'd215) begin
      errors++;
      $display("FAIL oversize: err=%b vld=%b size=%0d credit=%0d expected 1/1/40/215", err, dma_rd_req_vld, dma_rd_req_size, dut.credit_avail);
    end

    do_reset();
    dma_rd_req_rdy = 0;
    req0_addr = 64'h100; req0_size = 15'd1; gnt0 = 1;
    tick();
    gnt0 = 0; req1_addr = 64'h200; req1_size = 15'd1; gnt1 = 1;
    settle();
    checks++;
    if (req1_rdy !== 1'b0 || gnt_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_grant_rdy: rdy1=%b busy=%b expected 0/1", req1_rdy, gnt_busy);
    end
    tick();
    gnt1 = 0;
    settle();
    checks++;
    if (err !== 1'b1 || dma_rd_req_addr !== 64'h100 || dut.credit_avail !== 9'd254) begin
      errors++;
      $display("FAIL busy_grant: err=%b addr=%h credit=%0d expected 1/100/254", err, dma_rd_req_addr, dut.credit_avail);
    end

    credit_ret = 1;
    dma_rd_req_rdy = 1;
    for (int i = 0; i < 3; i++) tick();
    credit_ret = 0;
    settle();
    checks++;
    if (dut.credit_avail !== 9'd256) begin
      errors++;
      $display("FAIL credit_saturate: credit=%0d expected 256", dut.credit_avail);
    end
  endtask

`ifdef NVDLA_CDMA_WT_REQ_PERF_EN
  task automatic test_perf();
    do_reset();
    dma_rd_req_rdy = 0;
    req0_addr = 64'h10; req0_size = 15'd0; gnt0 = 1;
    tick();
    gnt0 = 0;
    req1_vld = 1;
    for (int i = 0; i < 10; i++) tick();
    req1_vld = 0;
    settle();
    checks++;
    if (perf_stall_cnt !== 32'd10) begin
      errors++;
      $display("FAIL perf_stall: got %0d expected 10", perf_stall_cnt);
    end
    dma_rd_req_rdy = 1;
    req1_addr = 64'h20; req1_size = 15'd0;
    for (int i = 0; i < 3; i++) begin
      gnt1 = 1;
      tick();
    end
    gnt1 = 0;
    settle();
    checks++;
    if (perf_req1_cnt !== 32'd3 || perf_req0_cnt !== 32'd1 || perf_stall_cnt !== 32'd10) begin
      errors++;
      $display("FAIL perf_accepts: req1=%0d req0=%0d stall=%0d expected 3/1/10", perf_req1_cnt, perf_req0_cnt, perf_stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_credit();
    test_tags();
    test_errors();
`ifdef NVDLA_CDMA_WT_REQ_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
